baud_gen_frac: RTL and testbench
================================

# baud_gen_frac

Fractional-divisor baud tick generator for the UART datapath, driving the RX sampler and TX shifter from one system clock. It generalises the fixed integer baud generator with a runtime-programmable divisor (integer plus fractional part), parametrised widths, and a half-period first RX tick for sample centring. Each channel latches the divisor when it activates, so a divisor write never disturbs a frame in progress.

## Interface
- OSC_FREQ, 100_000_000: system clock frequency in Hz; used only for the reset divisor.
- BAUD_RATE, 115_200: baud rate selected at reset.
- NO_OF_SAMPLE, 16: oversample periods per bit, ≥2.
- DIV_INT_W, 16: integer divisor width.
- DIV_FRAC_W, 4: fractional divisor width F.
- Derived DW = DIV_INT_W+DIV_FRAC_W. DEFAULT_DIV = floor(OSC_FREQ·2^F / (BAUD_RATE·NO_OF_SAMPLE)). Defaults give 868 = 54 + 4/16.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- div_wr  in  1  one-cycle strobe; loads div_in into the shadow divisor.
- div_in  in  DW  {integer I, fraction Fr} in clock cycles per oversample period.
- rx_active  in  1  RX channel enable, level.
- tx_active  in  1  TX channel enable, level.
- baud_en_rx  out  1  one-cycle pulse per oversample period.
- baud_en_tx  out  1  one-cycle pulse per bit period (NO_OF_SAMPLE oversample periods).
- div_cur  out  DW  current shadow divisor.
- div_rej  out  1  one-cycle pulse; the write was rejected.

## Operation
**Shadow divisor**
- Reset value is DEFAULT_DIV.
- div_wr with I≥2 loads the shadow on that edge.
- div_wr with I<2 is ignored; div_rej is high the next cycle.

**Channel states** (identical and independent for RX and TX)
- IDLE: count=0, acc=0, tick low.
- IDLE→RUN on the first edge sampling active=1. On that edge the channel latches the shadow into its private divisor (I_c, Fr_c) and the first period begins.
- RUN→IDLE on any edge sampling active=0. Counters clear and the tick output is low after that edge.

**Period length**
- At each period start: sum = acc + Fr_c (F+1 bits); period P = I_c + sum[F]; acc ← sum[F-1:0].
- The nth regular period therefore lasts I_c + (1 if floor(n·Fr_c/2^F) increments, else 0).
- The count runs 0..P-1. The tick register is set on the edge where count==P-1; the next period starts on the same edge.

**RX**
- The first period after activation is a centring period of max(1, I_c>>1) cycles. It does not touch acc.
- All later periods are regular, starting with n=1.
- baud_en_rx pulses at the end of every period, including the centring period.

**TX**
- All periods are regular.
- A sample counter (0..NO_OF_SAMPLE-1) advances at each period end. baud_en_tx pulses when it wraps from NO_OF_SAMPLE-1 to 0.
- The first baud_en_tx comes one full bit after activation.

**Boundary and simultaneous events**
- div_wr on the activation edge: the channel latches the old shadow. The new value applies from the next activation.
- A divisor write while in RUN never changes I_c or Fr_c.
- rx_active and tx_active assert together: the channels are fully independent with no shared counters.
- rst mid-period: immediate clear. Both channels go to IDLE, outputs go to 0 and the shadow returns to DEFAULT_DIV.

## Timing
- All outputs are registered. Reset values: baud_en_rx=0, baud_en_tx=0, div_rej=0, div_cur=DEFAULT_DIV.
- Latency rule: with active first sampled high at edge E0, the first tick is high in the cycle after edge E0+P1-1, where P1 is the first period length.
- Each tick is exactly one cycle wide. Minimum tick spacing is 2 cycles for TX; the RX centring tick can come 1 cycle after activation.
- div_cur updates the cycle after div_wr. div_rej is high for exactly 1 cycle.
- Average oversample period is exactly I + Fr/2^F cycles. Accumulated error is bounded below one clock at every tick.

## Test plan
- Reset defaults: assert rst mid-run → all outputs 0, div_cur=868. Then activate TX → baud_en_tx spacings are exactly 868, 868, 868 cycles; baud_en_rx stays 0.
- RX fractional pattern, default divisor: first baud_en_rx at 27 cycles, then spacings 54, 54, 54, 55 repeating.
- Reprogram: div_wr div_in=16·10+8 while TX runs → TX spacing stays 868 until tx_active drops. After re-activation, oversample periods alternate 10, 11 and bit ticks come every 168 cycles.
- Reject: div_wr with I=1 → div_rej pulses one cycle; div_cur and tick spacing are unchanged.
- Deactivate mid-period: drop rx_active at count 30 → no baud_en_rx follows. Re-assert → first tick again at 27 cycles.
- Async reset mid-period and simultaneous activation: assert rst at count 40 → outputs 0 immediately. Raise rx_active and tx_active together with a div_wr on the same edge → both channels use the old divisor and their ticks match independent single-channel runs.

Source files
------------

// File: rtl/baud_gen_frac.sv
// Fractional baud tick generator: one shared shadow divisor, independent RX/TX channels.
// All outputs registered; each channel latches the divisor on activation so writes never disturb a running frame.

module baud_gen_frac_chan #(
    parameter int DIV_INT_W    = 16,
    parameter int DIV_FRAC_W   = 4,
    parameter int NO_OF_SAMPLE = 16,
    parameter bit RX_MODE      = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active_i,
    input  logic [DIV_INT_W-1:0]  div_int_i,
    input  logic [DIV_FRAC_W-1:0] div_frac_i,
    output logic                  tick_o
);
    localparam int PW = DIV_INT_W + 1;
    localparam int SW = (NO_OF_SAMPLE > 2) ? $clog2(NO_OF_SAMPLE) : 1;
    localparam logic [SW-1:0] LAST = SW'(NO_OF_SAMPLE - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         per_q, per_d;
    logic [DIV_FRAC_W-1:0] acc_q, acc_d;
    logic [DIV_INT_W-1:0]  int_q, int_d;
    logic [DIV_FRAC_W-1:0] frac_q, frac_d;
    logic [SW-1:0]         samp_q, samp_d;
    logic                  tick_q, tick_d;

    logic                  run;
    logic [PW-1:0]         cur_cnt, cur_per, centre_per, first_per;
    logic [DIV_INT_W-1:0]  cur_int, half;
    logic [DIV_FRAC_W-1:0] cur_frac, cur_acc, first_acc;
    logic [SW-1:0]         cur_samp;
    logic [DIV_FRAC_W:0]   sum0, sum;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        per_d    = per_q;
        acc_d    = acc_q;
        int_d    = int_q;
        frac_d   = frac_q;
        samp_d   = samp_q;
        tick_d   = 1'b0;
        run      = 1'b0;
        cur_cnt  = cnt_q;
        cur_per  = per_q;
        cur_int  = int_q;
        cur_frac = frac_q;
        cur_acc  = acc_q;
        cur_samp = samp_q;
        sum      = '0;

        // Candidate first period lengths, computed from the shadow as seen on the activation edge.
        half       = div_int_i >> 1;
        centre_per = (half == '0) ? PW'(1) : {1'b0, half};
        sum0       = {1'b0, div_frac_i};
        first_per  = {1'b0, div_int_i} + PW'(sum0[DIV_FRAC_W]);
        first_acc  = sum0[DIV_FRAC_W-1:0];

        case (state_q)
            S_IDLE: begin
                if (active_i) begin
                    state_d  = S_RUN;
                    int_d    = div_int_i;
                    frac_d   = div_frac_i;
                    cur_int  = div_int_i;
                    cur_frac = div_frac_i;
                    cur_cnt  = '0;
                    cur_samp = '0;
                    cur_per  = RX_MODE ? centre_per : first_per;
                    cur_acc  = RX_MODE ? '0 : first_acc;
                    run      = 1'b1;
                end
            end
            default: begin
                if (active_i) begin
                    run = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                    samp_d  = '0;
                end
            end
        endcase

        if (run) begin
            per_d  = cur_per;
            acc_d  = cur_acc;
            samp_d = cur_samp;
            if (cur_cnt == cur_per - PW'(1)) begin
                // Period ends here; the next regular period starts on this same edge.
                sum    = {1'b0, cur_acc} + {1'b0, cur_frac};
                per_d  = {1'b0, cur_int} + PW'(sum[DIV_FRAC_W]);
                acc_d  = sum[DIV_FRAC_W-1:0];
                cnt_d  = '0;
                samp_d = (cur_samp == LAST) ? '0 : cur_samp + SW'(1);
                tick_d = RX_MODE ? 1'b1 : (cur_samp == LAST);
            end else begin
                cnt_d = cur_cnt + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            acc_q   <= '0;
            int_q   <= '0;
            frac_q  <= '0;
            samp_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            acc_q   <= acc_d;
            int_q   <= int_d;
            frac_q  <= frac_d;
            samp_q  <= samp_d;
            tick_q  <= tick_d;
        end
    end

    assign tick_o = tick_q;
endmodule

module baud_gen_frac #(
    parameter int OSC_FREQ     = 100_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int NO_OF_SAMPLE = 16,
    parameter int DIV_INT_W    = 16,
    parameter int DIV_FRAC_W   = 4,
    parameter int DW           = DIV_INT_W + DIV_FRAC_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          div_wr,
    input  logic [DW-1:0] div_in,
    input  logic          rx_active,
    input  logic          tx_active,
    output logic          baud_en_rx,
    output logic          baud_en_tx,
    output logic [DW-1:0] div_cur,
    output logic          div_rej
);
    localparam longint DEFAULT_DIV_L = (longint'(OSC_FREQ) << DIV_FRAC_W) /
                                       (longint'(BAUD_RATE) * longint'(NO_OF_SAMPLE));
    localparam logic [DW-1:0] DEFAULT_DIV = DEFAULT_DIV_L[DW-1:0];

    logic [DW-1:0] shadow_q, shadow_d;
    logic          rej_q, rej_d;
    logic          wr_ok;

    // Integer parts below 2 would allow a zero- or one-cycle TX period, so they are refused.
    always_comb begin
        wr_ok    = div_in[DW-1:DIV_FRAC_W] >= DIV_INT_W'(2);
        shadow_d = (div_wr && wr_ok) ? div_in : shadow_q;
        rej_d    = div_wr && !wr_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= DEFAULT_DIV;
            rej_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            rej_q    <= rej_d;
        end
    end

    baud_gen_frac_chan #(
        .DIV_INT_W(DIV_INT_W), .DIV_FRAC_W(DIV_FRAC_W),
        .NO_OF_SAMPLE(NO_OF_SAMPLE), .RX_MODE(1'b1)
    ) u_rx (
        .clk(clk), .rst(rst), .active_i(rx_active),
        .div_int_i(shadow_q[DW-1:DIV_FRAC_W]), .div_frac_i(shadow_q[DIV_FRAC_W-1:0]),
        .tick_o(baud_en_rx)
    );

    baud_gen_frac_chan #(
        .DIV_INT_W(DIV_INT_W), .DIV_FRAC_W(DIV_FRAC_W),
        .NO_OF_SAMPLE(NO_OF_SAMPLE), .RX_MODE(1'b0)
    ) u_tx (
        .clk(clk), .rst(rst), .active_i(tx_active),
        .div_int_i(shadow_q[DW-1:DIV_FRAC_W]), .div_frac_i(shadow_q[DIV_FRAC_W-1:0]),
        .tick_o(baud_en_tx)
    );

    assign div_cur = shadow_q;
    assign div_rej = rej_q;
endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac with default parameters (divisor 868 = 54 + 4/16).
module tb_baud_gen_frac;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_wr = 1'b0;
    logic [19:0] div_in = '0;
    logic        rx_active = 1'b0;
    logic        tx_active = 1'b0;
    logic        baud_en_rx, baud_en_tx, div_rej;
    logic [19:0] div_cur;

    int tests = 0;
    int fails = 0;

    baud_gen_frac dut (
        .clk(clk), .rst(rst), .div_wr(div_wr), .div_in(div_in),
        .rx_active(rx_active), .tx_active(tx_active),
        .baud_en_rx(baud_en_rx), .baud_en_tx(baud_en_tx),
        .div_cur(div_cur), .div_rej(div_rej)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Edges until the selected tick is seen (-1 on timeout); also counts pulses of the other tick.
    task automatic wait_tick(input bit tx, input int limit, output int n, output int other);
        n = -1;
        other = 0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (tx ? baud_en_tx : baud_en_rx) begin
                n = i;
                break;
            end
            if (tx ? baud_en_rx : baud_en_tx) other++;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        int n, o, acc_o, tx_first;
        int rx_t[$];
        int exp_rx[5];
        int pat[8];
        exp_rx = '{27, 81, 135, 189, 244};
        pat    = '{54, 54, 54, 55, 54, 54, 54, 55};

        // Reset values
        repeat (3) step();
        check("rst_div_cur", div_cur, 868);
        check("rst_en_rx", baud_en_rx, 0);
        check("rst_en_tx", baud_en_tx, 0);
        check("rst_rej", div_rej, 0);
        rst = 1'b0;
        step();

        // Load 10.5, catch the RX centring tick, then reset while that tick is high
        div_wr = 1'b1; div_in = 20'd168;
        step();
        div_wr = 1'b0;
        check("wr_div_cur", div_cur, 168);
        check("wr_rej", div_rej, 0);
        rx_active = 1'b1;
        wait_tick(1'b0, 100, n, o);
        check("rx_centre_10p5", n, 5);
        rst = 1'b1;
        rx_active = 1'b0;
        #1;
        check("async_rst_en_rx", baud_en_rx, 0);
        check("async_rst_div_cur", div_cur, 868);
        step();
        rst = 1'b0;
        step();

        // TX with default divisor: bit ticks every 868, no RX ticks
        tx_active = 1'b1;
        acc_o = 0;
        for (int k = 0; k < 3; k++) begin
            wait_tick(1'b1, 1000, n, o);
            check($sformatf("tx_default_sp%0d", k), n, 868);
            acc_o += o;
        end
        check("tx_default_no_rx", acc_o, 0);
        tx_active = 1'b0;
        step();

        // RX fractional pattern with default divisor
        rx_active = 1'b1;
        wait_tick(1'b0, 100, n, o);
        check("rx_first", n, 27);
        for (int k = 0; k < 8; k++) begin
            wait_tick(1'b0, 100, n, o);
            check($sformatf("rx_sp%0d", k), n, pat[k]);
        end

        // Deactivate with the count at 30: no further tick; re-activate restarts centring
        repeat (30) step();
        rx_active = 1'b0;
        wait_tick(1'b0, 100, n, o);
        check("rx_deact_no_tick", n, -1);
        rx_active = 1'b1;
        wait_tick(1'b0, 100, n, o);
        check("rx_react_first", n, 27);
        rx_active = 1'b0;
        step();

        // Reprogram while TX runs: the running channel keeps 868
        tx_active = 1'b1;
        wait_tick(1'b1, 1000, n, o);
        check("tx_prog_first", n, 868);
        div_wr = 1'b1; div_in = 20'd168;
        step();
        div_wr = 1'b0;
        check("tx_prog_div_cur", div_cur, 168);
        wait_tick(1'b1, 1000, n, o);
        check("tx_prog_keep0", n, 868 - 1);  // one edge spent on the write
        wait_tick(1'b1, 1000, n, o);
        check("tx_prog_keep1", n, 868);
        tx_active = 1'b0;
        step();
        tx_active = 1'b1;
        wait_tick(1'b1, 1000, n, o);
        check("tx_new_first", n, 168);
        wait_tick(1'b1, 1000, n, o);
        check("tx_new_sp", n, 168);
        tx_active = 1'b0;
        rx_active = 1'b1;
        wait_tick(1'b0, 100, n, o);
        check("rx_new_centre", n, 5);
        for (int k = 0; k < 4; k++) begin
            wait_tick(1'b0, 100, n, o);
            check($sformatf("rx_new_sp%0d", k), n, (k % 2 == 0) ? 10 : 11);
        end
        rx_active = 1'b0;
        step();

        // Rejected write: I = 1
        div_wr = 1'b1; div_in = {16'd1, 4'd3};
        step();
        div_wr = 1'b0;
        check("rej_pulse", div_rej, 1);
        check("rej_div_cur", div_cur, 168);
        step();
        check("rej_one_cycle", div_rej, 0);
        rx_active = 1'b1;
        wait_tick(1'b0, 100, n, o);
        check("rej_rx_centre", n, 5);
        wait_tick(1'b0, 100, n, o);
        check("rej_rx_sp0", n, 10);
        wait_tick(1'b0, 100, n, o);
        check("rej_rx_sp1", n, 11);
        rx_active = 1'b0;
        step();

        // Async reset at count 40 of a running TX channel
        tx_active = 1'b1;
        repeat (41) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst40_en_tx", baud_en_tx, 0);
        check("rst40_en_rx", baud_en_rx, 0);
        check("rst40_rej", div_rej, 0);
        check("rst40_div_cur", div_cur, 868);
        tx_active = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Simultaneous activation with a write on the same edge: both channels use 868
        div_wr = 1'b1; div_in = 20'd168;
        rx_active = 1'b1; tx_active = 1'b1;
        tx_first = -1;
        for (int i = 1; i <= 900; i++) begin
            @(posedge clk); #1;
            if (i == 1) div_wr = 1'b0;
            if (baud_en_rx) rx_t.push_back(i);
            if (baud_en_tx && tx_first < 0) tx_first = i;
        end
        for (int k = 0; k < 5; k++)
            check($sformatf("sim_rx_t%0d", k), (k < rx_t.size()) ? rx_t[k] : -1, exp_rx[k]);
        check("sim_tx_first", tx_first, 868);
        check("sim_div_cur", div_cur, 168);
        rx_active = 1'b0; tx_active = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
